// File: rtl/alu_seq_calculator_n_bit.sv
// Multi-cycle signed N-bit ALU (add/sub, shift-add mul, restoring div) with a 2N-bit result.
// Each falling rst starts one operation; the result is finalised in the first DONE cycle.
module alu_seq_calculator_n_bit #(
  parameter int DATA_WIDTH   = 4,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [2:0]              op,
  output logic [RESULT_WIDTH-1:0] result,
  output logic                    valid_result
);
  localparam int N  = DATA_WIDTH;
  localparam int RW = RESULT_WIDTH;
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic [N-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic [N-1:0]  shf_q, shf_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [RW-1:0] result_q, result_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  mag_a, mag_b;
  logic [N:0]    rem_sh;
  logic [RW-1:0] va, vb, q_ext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    shf_d    = shf_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    valid_d  = valid_q;

    mag_a  = a[N-1] ? (~a + 1'b1) : a;
    mag_b  = b[N-1] ? (~b + 1'b1) : b;
    rem_sh = {rem_q, shf_q[N-1]};
    // Signed operands rebuilt from sign + magnitude so -2^(N-1) round-trips exactly.
    va     = sa_q ? (~{{N{1'b0}}, ma_q} + 1'b1) : {{N{1'b0}}, ma_q};
    vb     = sb_q ? (~{{N{1'b0}}, mb_q} + 1'b1) : {{N{1'b0}}, mb_q};
    q_ext  = {{N{1'b0}}, quot_q};

    case (state_q)
      S_LOAD: begin
        op_d   = op;
        sa_d   = a[N-1];
        sb_d   = b[N-1];
        ma_d   = mag_a;
        mb_d   = mag_b;
        shf_d  = (op == OP_DIV) ? mag_a : mag_b;
        acc_d  = '0;
        rem_d  = '0;
        quot_d = '0;
        cnt_d  = '0;
        state_d = (op == OP_MUL || op == OP_DIV) ? S_EXEC : S_DONE;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          if (shf_q[0]) acc_d = acc_q + ({{N{1'b0}}, ma_q} << cnt_q);
          shf_d = shf_q >> 1;
        end else begin
          shf_d = shf_q << 1;
          if (rem_sh >= {1'b0, mb_q}) begin
            rem_d  = N'(rem_sh - {1'b0, mb_q});
            quot_d = {quot_q[N-2:0], 1'b1};
          end else begin
            rem_d  = N'(rem_sh);
            quot_d = {quot_q[N-2:0], 1'b0};
          end
        end
        if (cnt_q == CW'(N-1)) state_d = S_DONE;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      S_DONE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          case (op_q)
            OP_ADD:  result_d = va + vb;
            OP_SUB:  result_d = va - vb;
            OP_MUL:  result_d = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
            OP_DIV:  result_d = (mb_q == '0) ? '0 :
                                ((sa_q ^ sb_q) ? (~q_ext + 1'b1) : q_ext);
            default: result_d = '0;
          endcase
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      shf_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      shf_q    <= shf_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result       = result_q;
  assign valid_result = valid_q;
endmodule
